// File: rtl/computer_move_engine.sv
// Tic-tac-toe computer move selector. It scans for a winning line, then for a
// line to block, then falls back to a fixed cell preference order.
module computer_move_engine #(
  parameter int PREFER_CENTER = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  input  logic [1:0] pos9,
  output logic [3:0] computer_position,
  output logic       pc,
  output logic       busy,
  output logic       no_move
);

  // state      | meaning
  // IDLE       | waiting for start; board snapshot taken on start
  // SCAN_WIN   | one line per cycle, looking for two computer cells + one empty
  // SCAN_BLOCK | one line per cycle, looking for two player cells + one empty
  // PICK       | no line hit; take first empty cell in preference order
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SCAN_WIN   = 2'd1,
    SCAN_BLOCK = 2'd2,
    PICK       = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      line_q, line_d;
  logic [8:0][1:0] board_q, board_in;
  logic [3:0]      pos_q, pos_d;
  logic            pc_q, pc_d;
  logic            no_move_q, no_move_d;
  logic            snap;

  logic [3:0]      ia, ib, ic;
  logic [1:0]      va, vb, vc;
  logic [1:0]      owner;
  logic            line_hit;
  logic [3:0]      hit_idx;
  logic            pick_found;
  logic [3:0]      pick_idx;
  logic [3:0]      cand;

  assign board_in = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};

  function automatic logic [3:0] line_cell(input logic [2:0] ln, input logic [1:0] slot);
    logic [11:0] cells;
    case (ln)
      3'd0:    cells = {4'd0, 4'd1, 4'd2};
      3'd1:    cells = {4'd3, 4'd4, 4'd5};
      3'd2:    cells = {4'd6, 4'd7, 4'd8};
      3'd3:    cells = {4'd0, 4'd3, 4'd6};
      3'd4:    cells = {4'd1, 4'd4, 4'd7};
      3'd5:    cells = {4'd2, 4'd5, 4'd8};
      3'd6:    cells = {4'd0, 4'd4, 4'd8};
      default: cells = {4'd2, 4'd4, 4'd6};
    endcase
    case (slot)
      2'd0:    line_cell = cells[11:8];
      2'd1:    line_cell = cells[7:4];
      default: line_cell = cells[3:0];
    endcase
  endfunction

  function automatic logic [3:0] pick_order(input logic [3:0] rank);
    if (PREFER_CENTER != 0) begin
      case (rank)
        4'd0:    pick_order = 4'd4;
        4'd1:    pick_order = 4'd0;
        4'd2:    pick_order = 4'd2;
        4'd3:    pick_order = 4'd6;
        4'd4:    pick_order = 4'd8;
        4'd5:    pick_order = 4'd1;
        4'd6:    pick_order = 4'd3;
        4'd7:    pick_order = 4'd5;
        default: pick_order = 4'd7;
      endcase
    end else begin
      pick_order = rank;
    end
  endfunction

  // Line evaluation; value 11 never equals an owner code so it never counts.
  always_comb begin
    ia       = line_cell(line_q, 2'd0);
    ib       = line_cell(line_q, 2'd1);
    ic       = line_cell(line_q, 2'd2);
    va       = board_q[ia];
    vb       = board_q[ib];
    vc       = board_q[ic];
    owner    = (state_q == SCAN_BLOCK) ? 2'b01 : 2'b10;
    line_hit = 1'b0;
    hit_idx  = ia;
    if (va == owner && vb == owner && vc == 2'b00) begin
      line_hit = 1'b1;
      hit_idx  = ic;
    end else if (va == owner && vb == 2'b00 && vc == owner) begin
      line_hit = 1'b1;
      hit_idx  = ib;
    end else if (va == 2'b00 && vb == owner && vc == owner) begin
      line_hit = 1'b1;
      hit_idx  = ia;
    end
  end

  // Walk the preference order backwards so the earliest empty cell wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 4'd0;
    cand       = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      cand = pick_order(4'(i));
      if (board_q[cand] == 2'b00) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    pos_d     = pos_q;
    pc_d      = 1'b0;
    no_move_d = 1'b0;
    snap      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          snap    = 1'b1;
          line_d  = 3'd0;
          state_d = SCAN_WIN;
        end
      end
      SCAN_WIN: begin
        if (line_hit) begin
          pos_d   = hit_idx;
          pc_d    = 1'b1;
          state_d = IDLE;
        end else if (line_q == 3'd7) begin
          line_d  = 3'd0;
          state_d = SCAN_BLOCK;
        end else begin
          line_d  = line_q + 3'd1;
        end
      end
      SCAN_BLOCK: begin
        if (line_hit) begin
          pos_d   = hit_idx;
          pc_d    = 1'b1;
          state_d = IDLE;
        end else if (line_q == 3'd7) begin
          line_d  = 3'd0;
          state_d = PICK;
        end else begin
          line_d  = line_q + 3'd1;
        end
      end
      PICK: begin
        if (pick_found) begin
          pos_d = pick_idx;
          pc_d  = 1'b1;
        end else begin
          no_move_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      line_q    <= 3'd0;
      board_q   <= '0;
      pos_q     <= 4'd0;
      pc_q      <= 1'b0;
      no_move_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      pos_q     <= pos_d;
      pc_q      <= pc_d;
      no_move_q <= no_move_d;
      if (snap) board_q <= board_in;
    end
  end

  assign computer_position = pos_q;
  assign pc                = pc_q;
  assign no_move           = no_move_q;
  assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_computer_move_engine.sv
// Directed bench for computer_move_engine: scan latencies, priorities,
// fallback order, full-board handling, reset abort and start filtering.
module tb_computer_move_engine;

  logic            clock = 1'b0;
  logic            reset;
  logic            start;
  logic [8:0][1:0] bd;
  logic [3:0]      cp_a, cp_b;
  logic            pc_a, pc_b, busy_a, busy_b, nm_a, nm_b;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  computer_move_engine #(.PREFER_CENTER(1)) dut_a (
    .clock(clock), .reset(reset), .start(start),
    .pos1(bd[0]), .pos2(bd[1]), .pos3(bd[2]), .pos4(bd[3]), .pos5(bd[4]),
    .pos6(bd[5]), .pos7(bd[6]), .pos8(bd[7]), .pos9(bd[8]),
    .computer_position(cp_a), .pc(pc_a), .busy(busy_a), .no_move(nm_a)
  );

  computer_move_engine #(.PREFER_CENTER(0)) dut_b (
    .clock(clock), .reset(reset), .start(start),
    .pos1(bd[0]), .pos2(bd[1]), .pos3(bd[2]), .pos4(bd[3]), .pos5(bd[4]),
    .pos6(bd[5]), .pos7(bd[6]), .pos8(bd[7]), .pos9(bd[8]),
    .computer_position(cp_b), .pc(pc_b), .busy(busy_b), .no_move(nm_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one start pulse, then count edges after E0 until a strobe appears.
  task automatic do_move(input string tag, input int exp_edge, input int exp_pos,
                         input int exp_pc, input int exp_nm);
    int n;
    bit got;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    check({tag, "_busy"}, int'(busy_a), 1);
    n = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clock);
      n++;
      #1;
      if (pc_a || nm_a) got = 1'b1;
    end
    check({tag, "_lat"}, n, exp_edge);
    check({tag, "_pc"}, int'(pc_a), exp_pc);
    check({tag, "_nm"}, int'(nm_a), exp_nm);
    check({tag, "_pos"}, int'(cp_a), exp_pos);
    check({tag, "_busy_strobe"}, int'(busy_a), 0);
    @(posedge clock);
    #1;
    check({tag, "_one_cycle"}, int'(pc_a | nm_a), 0);
  endtask

  task automatic count_strobes(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      #1;
      if (pc_a || nm_a) cnt++;
    end
  endtask

  initial begin
    int n, cnt;
    bit got;
    reset = 1'b1;
    start = 1'b0;
    bd    = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_pc", int'(pc_a), 0);
    check("rst_nm", int'(nm_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_pos", int'(cp_a), 0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Empty board: fallback at E17; center vs first cell.
    bd = '0;
    do_move("empty", 17, 4, 1, 0);
    check("empty_pc0_pos", int'(cp_b), 0);

    // Win on line 0 at E1.
    bd = '0; bd[0] = 2'b10; bd[1] = 2'b10; bd[3] = 2'b01;
    do_move("win_l0", 1, 2, 1, 0);

    // Block on line 1 at E10.
    bd = '0; bd[3] = 2'b01; bd[4] = 2'b01; bd[0] = 2'b10;
    do_move("block_l1", 10, 5, 1, 0);

    // Win on line 2 preferred over block on line 0.
    bd = '0; bd[6] = 2'b10; bd[7] = 2'b10; bd[0] = 2'b01; bd[1] = 2'b01;
    do_move("win_over_block", 3, 8, 1, 0);

    // Full board: no_move at E17, position retains 8.
    bd = {2'b11, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b10};
    do_move("full", 17, 8, 0, 1);

    // 11 next to a computer cell must not look like a win.
    bd = '0; bd[0] = 2'b11; bd[1] = 2'b10;
    do_move("occ11", 17, 4, 1, 0);

    // Center taken by 11: fallback goes to cell 0.
    bd = '0; bd[4] = 2'b11;
    do_move("center_busy", 17, 0, 1, 0);

    // Diagonal win on line 6 at E7.
    bd = '0; bd[0] = 2'b10; bd[4] = 2'b10;
    do_move("diag", 7, 8, 1, 0);

    // Reset at E5 aborts the scan with no strobe.
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (4) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    check("abort_busy", int'(busy_a), 0);
    check("abort_pos", int'(cp_a), 0);
    reset = 1'b0;
    count_strobes(20, cnt);
    check("abort_strobes", cnt, 0);

    // Start pulse and board change during the scan are ignored.
    bd = '0; bd[0] = 2'b10; bd[4] = 2'b10;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    @(posedge clock);
    #1 start = 1'b1; bd = '0;
    @(posedge clock);
    #1 start = 1'b0;
    n = 2;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clock);
      n++;
      #1;
      if (pc_a || nm_a) got = 1'b1;
    end
    check("snap_lat", n, 7);
    check("snap_pos", int'(cp_a), 8);
    count_strobes(25, cnt);
    check("no_queue", cnt, 0);

    // Start held high: next request starts on the edge after each strobe.
    bd = '0; bd[0] = 2'b10; bd[1] = 2'b10;
    start = 1'b1;
    n = 0;
    got = 1'b0;
    while (n < 20 && !got) begin
      @(posedge clock);
      n++;
      #1;
      if (pc_a) got = 1'b1;
    end
    check("held_first", int'(pc_a), 1);
    n = 0;
    got = 1'b0;
    while (n < 20 && !got) begin
      @(posedge clock);
      n++;
      #1;
      if (pc_a) got = 1'b1;
    end
    check("held_gap", n, 2);
    start = 1'b0;
    repeat (3) @(posedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
